nmr_echo_gate: RTL
==================

# nmr_echo_gate

Receive-side counterpart of the NMR pulse sequencer. It watches the sequencer's sync/pulse/blank outputs and opens one ADC acquisition window after each blanking interval ends: the echo after the A-pulse, then after every B-pulse. Captured samples are tagged with the echo index and streamed out over a ready/valid interface through a small FIFO to the DMA path.

## Interface
Parameters:
- DATA_W, 16, ADC sample width (≤16)
- FIFO_DEPTH, 16, output FIFO entries, power of two

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enbl  in  1  gate enable; low forces IDLE (FIFO still drains)
- sync_in  in  1  sequencer sync (high during A-pulse)
- pulse_in  in  1  sequencer pulse output
- blank_in  in  1  sequencer receiver-blank output
- adc_valid  in  1  ADC sample strobe
- adc_data  in  DATA_W  ADC sample, two's complement
- AcqLen_in  in  16  samples per window
- EchoMax_in  in  16  windows per sequence
- m_tdata  out  32  {echo_idx[15:0], sign-extended sample[15:0]}
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last sample of a window
- busy_out  out  1  state ≠ IDLE/DONE
- overflow_out  out  1  sticky: sample dropped, FIFO full
- trunc_out  out  1  sticky: window cut short by pulse_in

## Operation
- Edge detect: registered sync_prv, blank_prv. sync_rise = sync_in & ~sync_prv; blank_fall = ~blank_in & blank_prv.
- States: IDLE, ARMED, ACQ, DONE.
- IDLE: on sync_rise & enbl -> ARMED; echo_idx←0; latch EchoMax_in; clear overflow_out, trunc_out. If latched EchoMax is 0 -> DONE instead.
- ARMED: on blank_fall -> ACQ; latch AcqLen_in into sample counter; if AcqLen is 0, count the window as complete immediately (no samples, no tlast).
- ACQ: each adc_valid pushes {echo_idx, sample} into the FIFO. tlast is set on the sample that brings the count to AcqLen. After the last sample: echo_idx+1; if echo_idx+1 == EchoMax -> DONE, else -> ARMED.
- Truncation: pulse_in high in ACQ closes the window. trunc_out←1, echo_idx+1, same next-state rule. No tlast is emitted for a truncated window.
- DONE: hold until sync_rise -> restart as from IDLE.
- sync_rise in any state other than IDLE/DONE restarts the sequence (ARMED, echo_idx 0). An open window is abandoned.
- FIFO full on a push: sample dropped, overflow_out←1, window counting continues.
- adc_valid outside ACQ is ignored.
- enbl low: state←IDLE next cycle; sticky flags hold.
- echo_idx is 16-bit and saturates at 0xFFFF.

## Timing
- Reset values: state IDLE, m_tvalid 0, m_tlast 0, m_tdata 0, busy_out 0, overflow_out 0, trunc_out 0, FIFO empty, echo_idx 0.
- blank_in falling at cycle n -> blank_fall at n+1 -> state ACQ at n+2. The first accepted sample is at n+2.
- Push at cycle k -> m_tvalid high at k+1 (registered FIFO output).
- Transfer occurs when m_tvalid & m_tready. m_tdata and m_tlast stay stable while m_tvalid & ~m_tready.
- Simultaneous push and pop on a full FIFO: the pop frees space first, so the push succeeds and there is no overflow.
- Sustained throughput: one sample per clock.

## Configuration
- NMR_ECHO_TIMESTAMP_EN defined:
  - m_tdata widens to 64 bits; upper 32 bits are the clk-cycle count since the last sync_rise, captured at push.
  - The counter wraps at 2^32.
- Not defined: m_tdata is 32 bits and there is no timestamp counter.

## Structure
- Shared package nmr_pkg holds:
  - the gate state enum
  - ECHO_IDX_W = 16
  - TDATA_W, derived from NMR_ECHO_TIMESTAMP_EN
- Sub-module nmr_sync_fifo: single-clock FIFO, registered output, full/empty flags, parameterised width and depth.

## Test plan
- Reset, EchoMax=2, AcqLen=4, one blank fall per echo, continuous adc_valid -> 8 beats; echo_idx 0,0,0,0,1,1,1,1; tlast on beats 4 and 8; state DONE.
- AcqLen=3, pulse_in asserted after the 2nd sample of echo 0 -> 2 beats with no tlast; trunc_out=1; next window tagged echo_idx 1.
- m_tready low, FIFO_DEPTH=16, AcqLen=20 -> 16 beats buffered, overflow_out=1, tlast lost. A later sync_rise clears overflow_out.
- sync_rise mid-window of echo 1 -> state ARMED, echo_idx 0; the following window is tagged 0.
- EchoMax=0 -> no samples output, busy_out stays 0.
- enbl dropped during ACQ -> IDLE next cycle; queued FIFO beats still drain with m_tready=1.

Source files
------------

// File: rtl/nmr_pkg.sv
// nmr_pkg: shared definitions for the NMR echo acquisition gate.
//
// Contents:
//   gate_state_t  acquisition gate state encoding
//   ECHO_IDX_W    width of the echo index tag
//   SAMPLE_W      width of the sign-extended sample field in the beat
//   TDATA_W       width of the output stream word
//   idx_sat_inc   saturating echo index increment
//
// Build option: NMR_ECHO_TIMESTAMP_EN widens the output word to 64 bits
// and adds a 32-bit cycle timestamp above {echo_idx, sample}.

package nmr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DONE  = 2'd3
    } gate_state_t;

    localparam int ECHO_IDX_W = 16;
    localparam int SAMPLE_W   = 16;

`ifdef NMR_ECHO_TIMESTAMP_EN
    localparam int TS_W    = 32;
    localparam int TDATA_W = 64;
`else
    localparam int TDATA_W = 32;
`endif

    function automatic logic [ECHO_IDX_W-1:0] idx_sat_inc(input logic [ECHO_IDX_W-1:0] v);
        return (v == '1) ? v : v + ECHO_IDX_W'(1);
    endfunction

endpackage

// File: rtl/nmr_sync_fifo.sv
// nmr_sync_fifo: single-clock FIFO with flag outputs.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   wr_en      push request; accepted when not full, or when a pop
//              happens in the same cycle (the pop frees the slot first)
//   wr_data    push data
//   rd_en      pop request; ignored when empty
//   rd_data    head entry, driven only from registers; zero when empty
//   full       DEPTH entries held
//   empty      no entries held
//
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.

module nmr_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nmr_echo_gate.sv
// nmr_echo_gate: receive-side acquisition gate for the NMR pulse sequencer.
// Opens one ADC window after each receiver-blank interval, tags samples with
// the echo index and streams them out through a FIFO.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   enbl           gate enable; low forces IDLE, FIFO keeps draining
//   sync_in        sequencer sync (A-pulse marker)
//   pulse_in       sequencer pulse; closes an open window early
//   blank_in       receiver blank; its falling edge opens a window
//   adc_valid      ADC sample strobe
//   adc_data       ADC sample, two's complement
//   AcqLen_in      samples per window
//   EchoMax_in     windows per sequence
//   m_tdata        {[timestamp,] echo_idx, sign-extended sample}
//   m_tvalid       output valid
//   m_tready       downstream ready
//   m_tlast        last sample of a complete window
//   busy_out       state is ARMED or ACQ
//   overflow_out   sticky, a sample was dropped on a full FIFO
//   trunc_out      sticky, a window was cut short by pulse_in
//
// Build option: NMR_ECHO_TIMESTAMP_EN adds a 32-bit cycle count since the
// last sync rise, captured at push, in m_tdata[63:32].
//
// state  | meaning
// IDLE   | waiting for a sync rise with enbl high
// ARMED  | sequence running, waiting for blank_in to fall
// ACQ    | window open, counting samples down to zero
// DONE   | all windows of the sequence taken, waiting for sync rise

module nmr_echo_gate
    import nmr_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enbl,
    input  logic               sync_in,
    input  logic               pulse_in,
    input  logic               blank_in,
    input  logic               adc_valid,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic [15:0]        AcqLen_in,
    input  logic [15:0]        EchoMax_in,
    output logic [TDATA_W-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               busy_out,
    output logic               overflow_out,
    output logic               trunc_out
);

    gate_state_t           state;
    logic                  sync_prv;
    logic                  blank_prv;
    logic                  sync_rise;
    logic                  blank_fall;
    logic [ECHO_IDX_W-1:0] echo_idx;
    logic [15:0]           echo_max;
    logic [15:0]           remaining;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  acq_take;
    logic                  samp_last;
    logic                  push_drop;
    logic                  seq_end;
    gate_state_t           close_state;
    logic [SAMPLE_W-1:0]   sample_ext;
    logic [TDATA_W:0]      push_word;
    logic [TDATA_W:0]      head_word;

    assign sample_ext = SAMPLE_W'($signed(adc_data));

    // A sync rise or pulse in the same cycle wins over the sample.
    assign acq_take  = (state == ST_ACQ) & enbl & ~sync_rise & ~pulse_in & adc_valid;
    assign samp_last = (remaining == 16'd1);
    assign fifo_pop  = m_tvalid & m_tready;
    assign push_drop = acq_take & fifo_full & ~fifo_pop;

    // Compare in 17 bits so a saturated index never matches by wrapping.
    assign seq_end     = (({1'b0, echo_idx} + 17'd1) == {1'b0, echo_max});
    assign close_state = seq_end ? ST_DONE : ST_ARMED;

`ifdef NMR_ECHO_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
        end else if (sync_rise) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign push_word = {samp_last, ts_cnt, echo_idx, sample_ext};
`else
    assign push_word = {samp_last, echo_idx, sample_ext};
`endif

    nmr_sync_fifo #(
        .WIDTH (TDATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acq_take),
        .wr_data (push_word),
        .rd_en   (fifo_pop),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_tvalid = ~fifo_empty;
    assign m_tlast  = head_word[TDATA_W];
    assign m_tdata  = head_word[TDATA_W-1:0];
    assign busy_out = (state == ST_ARMED) | (state == ST_ACQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            sync_prv     <= 1'b0;
            blank_prv    <= 1'b0;
            sync_rise    <= 1'b0;
            blank_fall   <= 1'b0;
            echo_idx     <= '0;
            echo_max     <= '0;
            remaining    <= '0;
            overflow_out <= 1'b0;
            trunc_out    <= 1'b0;
        end else begin
            sync_prv   <= sync_in;
            blank_prv  <= blank_in;
            sync_rise  <= sync_in & ~sync_prv;
            blank_fall <= ~blank_in & blank_prv;

            if (!enbl) begin
                state <= ST_IDLE;
            end else if (sync_rise) begin
                // Restart from any state; an open window is abandoned.
                echo_idx     <= '0;
                echo_max     <= EchoMax_in;
                overflow_out <= 1'b0;
                trunc_out    <= 1'b0;
                state        <= (EchoMax_in == 16'd0) ? ST_DONE : ST_ARMED;
            end else begin
                if (push_drop) begin
                    overflow_out <= 1'b1;
                end
                unique case (state)
                    ST_ARMED: begin
                        if (blank_fall) begin
                            if (AcqLen_in == 16'd0) begin
                                echo_idx <= idx_sat_inc(echo_idx);
                                state    <= close_state;
                            end else begin
                                remaining <= AcqLen_in;
                                state     <= ST_ACQ;
                            end
                        end
                    end
                    ST_ACQ: begin
                        if (pulse_in) begin
                            trunc_out <= 1'b1;
                            echo_idx  <= idx_sat_inc(echo_idx);
                            state     <= close_state;
                        end else if (adc_valid) begin
                            // Dropped samples still count toward the window.
                            remaining <= remaining - 16'd1;
                            if (samp_last) begin
                                echo_idx <= idx_sat_inc(echo_idx);
                                state    <= close_state;
                            end
                        end
                    end
                    ST_IDLE, ST_DONE: begin
                        state <= state;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
